fetch_stage: RTL and testbench

//  PC register, instruction-memory request and IF/ID pipeline latch for the 5-stage MIPS core.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage MIPS core: PC register, instruction-memory request
// and the IF/ID pipeline latch, with a FETCH/HALTED control FSM.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  input  logic             stall_PC,
  input  logic             stall_IFID,
  input  logic             flush_IFID,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      branch_tgt,
  input  logic [31:0]      jump_tgt,
  input  logic [31:0]      jr_tgt,
  input  logic             halt,
  output logic [31:0]      instr_IFID,
  output logic [31:0]      pcplus4_IFID,
  output logic             valid_IFID,
  output logic [CNT_W-1:0] fetch_count,
  output logic             state_dbg
);

  // Handshake: imem has no backpressure. imemload is taken only in a cycle
  // where imemREN && ihit, and ihit always refers to the current imemaddr.

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [31:0] PC_RESET = {PC_INIT[31:2], 2'b00};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_tgt;
  logic             stopped;
  logic             load_valid;
  logic [31:0]      instr_d, pcplus4_d;
  logic             valid_d;
  logic [CNT_W-1:0] count_d;

  assign imemaddr  = pc_q;
  assign imemREN   = (state_q == FETCH);
  assign state_dbg = (state_q == HALTED);
  assign pc_plus4  = pc_q + 32'd4;
  assign stopped   = (state_q == HALTED) || halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      pc_q         <= PC_RESET;
      instr_IFID   <= 32'h0;
      pcplus4_IFID <= 32'h0;
      valid_IFID   <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_IFID   <= instr_d;
      pcplus4_IFID <= pcplus4_d;
      valid_IFID   <= valid_d;
      fetch_count  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == FETCH && halt) state_d = HALTED;
  end

  always_comb begin
    redirect_tgt = branch_tgt;
    case (PCSrc)
      2'b01:   redirect_tgt = branch_tgt;
      2'b10:   redirect_tgt = jump_tgt;
      2'b11:   redirect_tgt = jr_tgt;
      default: redirect_tgt = branch_tgt;
    endcase
  end

  // A redirect beats stall_PC and any outstanding miss; the aborted miss is
  // simply forgotten because ihit is only ever qualified by the current PC.
  always_comb begin
    pc_d = pc_q;
    if (!stopped) begin
      if (PCSrc != 2'b00)        pc_d = {redirect_tgt[31:2], 2'b00};
      else if (!stall_PC && ihit) pc_d = pc_plus4;
    end
  end

  always_comb begin
    instr_d    = instr_IFID;
    pcplus4_d  = pcplus4_IFID;
    valid_d    = valid_IFID;
    load_valid = 1'b0;
    if (stopped || flush_IFID) begin
      instr_d   = 32'h0;
      pcplus4_d = 32'h0;
      valid_d   = 1'b0;
    end else if (stall_IFID) begin
      instr_d   = instr_IFID;
      pcplus4_d = pcplus4_IFID;
      valid_d   = valid_IFID;
    end else if (ihit) begin
      instr_d    = imemload;
      pcplus4_d  = pc_plus4;
      valid_d    = 1'b1;
      load_valid = 1'b1;
    end else begin
      instr_d   = 32'h0;
      pcplus4_d = 32'h0;
      valid_d   = 1'b0;
    end
  end

  // Saturating performance counter of real instructions entering IF/ID.
  always_comb begin
    count_d = fetch_count;
    if (load_valid && (fetch_count != {CNT_W{1'b1}}))
      count_d = fetch_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, vector table for streaming/miss/stall/
// redirect/flush, then hand sequences for saturation, PC wrap, halt and async reset.
module tb_fetch_stage;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit;
  logic [31:0]   imemload;
  logic          imemREN;
  logic [31:0]   imemaddr;
  logic          stall_PC, stall_IFID, flush_IFID;
  logic [1:0]    PCSrc;
  logic [31:0]   branch_tgt, jump_tgt, jr_tgt;
  logic          halt;
  logic [31:0]   instr_IFID, pcplus4_IFID;
  logic          valid_IFID;
  logic [CW-1:0] fetch_count;
  logic          state_dbg;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.PC_INIT(32'h0), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall_PC(stall_PC),
    .stall_IFID(stall_IFID), .flush_IFID(flush_IFID), .PCSrc(PCSrc),
    .branch_tgt(branch_tgt), .jump_tgt(jump_tgt), .jr_tgt(jr_tgt),
    .halt(halt), .instr_IFID(instr_IFID), .pcplus4_IFID(pcplus4_IFID),
    .valid_IFID(valid_IFID), .fetch_count(fetch_count), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        sp, si, fl;
    logic [1:0]  src;
    logic [31:0] e_pc, e_instr, e_p4;
    logic        e_v;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ih, logic [31:0] ld, logic sp, logic si, logic fl,
                              logic [1:0] src, logic [31:0] pc, logic [31:0] ins,
                              logic [31:0] p4, logic v, logic [3:0] cnt);
    vec_t r;
    r.ihit = ih; r.load = ld; r.sp = sp; r.si = si; r.fl = fl; r.src = src;
    r.e_pc = pc; r.e_instr = ins; r.e_p4 = p4; r.e_v = v; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ih, input logic [31:0] ld, input logic sp,
                       input logic si, input logic fl, input logic [1:0] src);
    ihit = ih; imemload = ld; stall_PC = sp; stall_IFID = si; flush_IFID = fl; PCSrc = src;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v, input logic [3:0] cnt,
                         input logic ren);
    chk({tag, ".imemaddr"}, imemaddr, pc);
    chk({tag, ".instr"}, instr_IFID, ins);
    chk({tag, ".pcplus4"}, pcplus4_IFID, p4);
    chk({tag, ".valid"}, {31'b0, valid_IFID}, {31'b0, v});
    chk({tag, ".count"}, {28'b0, fetch_count}, {28'b0, cnt});
    chk({tag, ".ren"}, {31'b0, imemREN}, {31'b0, ren});
    chk({tag, ".state"}, {31'b0, state_dbg}, {31'b0, ~ren});
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [3:0]  exp_cnt;

    nRST = 1'b0; halt = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    branch_tgt = 32'h40; jump_tgt = 32'h80; jr_tgt = 32'h103;

    // streaming, miss, stall, partial stalls, redirects, flushes
    tbl.push_back(mk(1, 32'h11, 0, 0, 0, 2'd0, 32'h04, 32'h11, 32'h04, 1, 4'd1));
    tbl.push_back(mk(1, 32'h22, 0, 0, 0, 2'd0, 32'h08, 32'h22, 32'h08, 1, 4'd2));
    tbl.push_back(mk(1, 32'h33, 0, 0, 0, 2'd0, 32'h0C, 32'h33, 32'h0C, 1, 4'd3));
    tbl.push_back(mk(1, 32'h44, 0, 0, 0, 2'd0, 32'h10, 32'h44, 32'h10, 1, 4'd4));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 2'd0, 32'h10, 32'h0,  32'h0,  0, 4'd4));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 2'd0, 32'h10, 32'h0,  32'h0,  0, 4'd4));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 2'd0, 32'h10, 32'h0,  32'h0,  0, 4'd4));
    tbl.push_back(mk(1, 32'h55, 0, 0, 0, 2'd0, 32'h14, 32'h55, 32'h14, 1, 4'd5));
    tbl.push_back(mk(1, 32'h66, 1, 1, 0, 2'd0, 32'h14, 32'h55, 32'h14, 1, 4'd5));
    tbl.push_back(mk(1, 32'h66, 1, 1, 0, 2'd0, 32'h14, 32'h55, 32'h14, 1, 4'd5));
    tbl.push_back(mk(1, 32'h66, 0, 0, 0, 2'd0, 32'h18, 32'h66, 32'h18, 1, 4'd6));
    tbl.push_back(mk(1, 32'h70, 0, 1, 0, 2'd0, 32'h1C, 32'h66, 32'h18, 1, 4'd6));
    tbl.push_back(mk(1, 32'h77, 1, 0, 0, 2'd0, 32'h1C, 32'h77, 32'h20, 1, 4'd7));
    tbl.push_back(mk(0, 32'h0,  1, 0, 1, 2'd1, 32'h40, 32'h0,  32'h0,  0, 4'd7));
    tbl.push_back(mk(1, 32'h88, 0, 0, 0, 2'd2, 32'h80, 32'h88, 32'h44, 1, 4'd8));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 2'd3, 32'h100, 32'h0, 32'h0,  0, 4'd8));
    tbl.push_back(mk(1, 32'h99, 0, 0, 1, 2'd0, 32'h104, 32'h0, 32'h0,  0, 4'd8));
    tbl.push_back(mk(1, 32'hAA, 0, 0, 0, 2'd0, 32'h108, 32'hAA, 32'h108, 1, 4'd9));
    tbl.push_back(mk(1, 32'hBB, 0, 1, 1, 2'd0, 32'h10C, 32'h0, 32'h0,  0, 4'd9));

    step();
    step();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ihit, tbl[i].load, tbl[i].sp, tbl[i].si, tbl[i].fl, tbl[i].src);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_p4,
              tbl[i].e_v, tbl[i].e_cnt, 1'b1);
    end

    // counter saturation at all-ones
    exp_pc = 32'h10C;
    exp_cnt = 4'd9;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + i, 1'b0, 1'b0, 1'b0, 2'b00);
      step();
      exp_pc = exp_pc + 32'd4;
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      chk_all($sformatf("sat%0d", i), exp_pc, 32'h1000 + i, exp_pc, 1'b1, exp_cnt, 1'b1);
    end

    // PC wrap: jr target low bits dropped, FFFF_FFFC + 4 -> 0
    jr_tgt = 32'hFFFF_FFFF;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b11);
    step();
    chk_all("wrap_redir", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 4'hF, 1'b1);
    drive(1'b1, 32'hCC, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    chk_all("wrap_hit", 32'h0, 32'hCC, 32'h0, 1'b1, 4'hF, 1'b1);

    // halt at PC 20 and stay parked
    branch_tgt = 32'h20;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01);
    step();
    chk_all("to20", 32'h20, 32'h0, 32'h0, 1'b0, 4'hF, 1'b1);
    halt = 1'b1;
    drive(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    chk_all("halt", 32'h20, 32'h0, 32'h0, 1'b0, 4'hF, 1'b0);
    halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      step();
      chk_all($sformatf("parked%0d", i), 32'h20, 32'h0, 32'h0, 1'b0, 4'hF, 1'b0);
    end

    // asynchronous reset mid-cycle recovers
    #2;
    nRST = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b1, 32'hDD, 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    chk_all("recover", 32'h4, 32'hDD, 32'h4, 1'b1, 4'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
